// File: rtl/ift_pkg.sv
// ift_pkg: shared IFT types and label width
package ift_pkg;
  localparam int IFT_TW = 32;
  typedef enum logic [1:0] {ARMED, ALARM, LOCKED} ift_sink_state_e;
endpackage

// File: rtl/ift_sat_counter.sv
// ift_sat_counter: saturating up-counter; clr with inc in the same cycle lands on 1
module ift_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt
);
  assign nxt = clr ? W'(inc) : (inc && cnt != '1) ? cnt + W'(1) : cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= nxt;
endmodule

// File: rtl/ift_sink_checker.sv
// ift_sink_checker: checks sink taint labels against a forbidden-label policy, latches
// alarm/violation statistics and forwards a declassified registered copy downstream
module ift_sink_checker
  import ift_pkg::*;
#(
  parameter int TW          = IFT_TW,
  parameter int CNT_W       = 16,
  parameter int LOCK_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic [TW-1:0]    d_t,
  input  logic [TW-1:0]    policy_mask,
  input  logic [TW-1:0]    declass_mask,
  input  logic             clear,
  input  logic             cnt_clr,
  output logic             q,
  output logic [TW-1:0]    q_t,
  output logic             q_vld,
  output logic             alarm,
  output logic             locked,
  output logic [TW-1:0]    alarm_label,
  output logic [TW-1:0]    alarm_union,
  output logic [CNT_W-1:0] viol_cnt
);
  ift_sink_state_e state;
  logic [TW-1:0] vlab;
  logic viol, lock_hit;
  logic [CNT_W-1:0] cnt_nxt;
  assign vlab = d_t & policy_mask;
  assign viol = en & |vlab;
  ift_sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .inc(viol), .clr(cnt_clr), .cnt(viol_cnt), .nxt(cnt_nxt)
  );
  // lock is judged on the counter value this violation produces, not the old one
  assign lock_hit = LOCK_THRESH != 0 && viol && 64'(cnt_nxt) >= 64'(LOCK_THRESH);
  always_ff @(posedge clk)
    if (rst) begin
      q <= 1'b0;
      q_t <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= en;
      if (en) begin
        q <= d;
        q_t <= d_t & ~declass_mask;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARMED;
      alarm <= 1'b0;
      locked <= 1'b0;
      alarm_label <= '0;
      alarm_union <= '0;
    end else begin
      case (state)
        ARMED:
          if (viol) begin
            state <= ALARM;
            alarm <= 1'b1;
            alarm_label <= vlab;
            alarm_union <= vlab;
          end
        ALARM:
          if (viol && clear) begin
            alarm_label <= vlab;
            alarm_union <= vlab;
          end else if (viol) begin
            alarm_union <= alarm_union | vlab;
          end else if (clear) begin
            state <= ARMED;
            alarm <= 1'b0;
            alarm_label <= '0;
            alarm_union <= '0;
          end
        LOCKED:
          if (viol) alarm_union <= alarm_union | vlab;
        default: begin
          state <= ARMED;
          alarm <= 1'b0;
          locked <= 1'b0;
        end
      endcase
      if (lock_hit) begin
        state <= LOCKED;
        alarm <= 1'b1;
        locked <= 1'b1;
      end
    end
endmodule

// File: doc/ift_sink_checker.md
# ift_sink_checker

Sink-side endpoint for the information-flow-tracking (IFT) instrumented datapath. It consumes one value/taint pair per sampled cycle from an instrumented hierarchy, where each taint signal is a label vector with one bit per information source. It checks the taint labels against a forbidden-label policy, raises and holds an alarm, and keeps violation statistics. It also forwards a registered, declassified copy of the pair downstream.

## Interface
Parameters:
- TW, 32, taint label width (one bit per source label)
- CNT_W, 16, width of the saturating violation counter
- LOCK_THRESH, 4, violation count at which the alarm becomes non-clearable; 0 disables locking

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe; d/d_t valid this cycle
- d  in  1  data value from the instrumented block
- d_t  in  TW  taint labels of d
- policy_mask  in  TW  labels forbidden at this sink
- declass_mask  in  TW  labels stripped on the forwarded path
- clear  in  1  alarm acknowledge (level, sampled each cycle)
- cnt_clr  in  1  zero the violation counter
- q  out  1  registered d
- q_t  out  TW  registered d_t & ~declass_mask
- q_vld  out  1  registered en
- alarm  out  1  alarm active
- locked  out  1  alarm is non-clearable
- alarm_label  out  TW  forbidden labels of the first violation since arm
- alarm_union  out  TW  OR of forbidden labels of all violations since arm
- viol_cnt  out  CNT_W  saturating count of violating samples

## Operation
- viol = en & |(d_t & policy_mask); vlab = d_t & policy_mask. This logic is combinational. All outputs are registered.
- The forwarding path captures q, q_t and q_vld every cycle. When en=0, q_vld=0, and q/q_t hold their previous values.
- FSM states: ARMED, ALARM, LOCKED.
  - ARMED, viol: go to ALARM. alarm_label <= vlab; alarm_union <= vlab.
  - ALARM, viol: alarm_union |= vlab. alarm_label is unchanged.
  - ALARM, clear & !viol: go to ARMED. alarm_label and alarm_union are zeroed.
  - ALARM, clear & viol: stay in ALARM. alarm_label and alarm_union are reloaded with vlab. A violation wins over clear.
  - Any state: if LOCK_THRESH != 0 and the incremented viol_cnt is >= LOCK_THRESH, go to LOCKED. This test uses the post-increment value.
  - LOCKED: clear is ignored. alarm_union continues to accumulate. Only rst exits LOCKED.
- alarm = (state != ARMED). locked = (state == LOCKED).
- viol_cnt increments on each viol and saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr zeroes it.
  - If cnt_clr and viol occur in the same cycle, viol_cnt is 1.
  - cnt_clr does not change the FSM state.
- policy_mask and declass_mask are sampled live each cycle. They are not latched.

## Timing
- Latency is 1 cycle from a sampled input to every output.
- Reset puts state in ARMED and sets all outputs to 0: q, q_t, q_vld, alarm, locked, alarm_label, alarm_union, viol_cnt.
- Asserting rst in the middle of an alarm, or while locked, returns to reset values on the next edge. rst has priority over every other input.
- en=0 never counts as a violation, regardless of d_t.

## Structure
- Package ift_pkg holds:
  - the state enum ift_sink_state_e (ARMED/ALARM/LOCKED)
  - the default label width constant IFT_TW = 32, shared with the rest of the IFT blocks
- Sub-module ift_sat_counter is a parameterized saturating counter with inc, clr and clear-plus-inc priority.

## Test plan
- Reset: after rst, all outputs are 0. Drive en=1, d_t=0x1, policy_mask=0x2 → alarm stays 0 and viol_cnt stays 0.
- Single violation: with policy_mask=0x6, drive en=1, d_t=0x3 → next cycle alarm=1, alarm_label=0x2, alarm_union=0x2, viol_cnt=1.
- Accumulate then clear: violations with d_t=0x2 and then d_t=0x4, followed by clear=1 and en=0 → alarm_label=0x2, alarm_union=0x6, viol_cnt=2; one cycle after clear, alarm=0 and both label registers are 0.
- Simultaneous clear and violation: in ALARM, drive clear=1 with d_t=0x4 → alarm stays 1, alarm_label=0x4, alarm_union=0x4.
- Lock: with LOCK_THRESH=4, apply 4 violations → locked=1 on the cycle after the 4th; clear has no effect; rst restores all outputs to 0.
- Forward path and saturation: with declass_mask=0xF0, drive en=1, d=1, d_t=0xFF → q=1, q_t=0x0F, q_vld=1. With CNT_W=2, apply 5 violations → viol_cnt=3.
